// File: rtl/fir_pkg.sv
// Shared helpers for the FIR stream stages: width arithmetic, rounding constant, buffer states.
// Latency: none (package only).
// Backpressure: n/a.
package fir_pkg;

  // System sample width used by the filter chain.
  localparam int SAMPLE_W = 16;

  // Occupancy states of the 2-entry stream buffer.
  typedef enum logic [1:0] {
    FILL_EMPTY = 2'd0,
    FILL_ONE   = 2'd1,
    FILL_TWO   = 2'd2
  } fill_e;

  // Full-precision width of a symmetric FIR output word.
  function automatic int out_width(int in_w, int coeff_w, int n_coeffs);
    return in_w + coeff_w + $clog2(n_coeffs) + 1;
  endfunction

  // Half-LSB constant added before a right shift; 0 when no shift is applied.
  function automatic logic [63:0] round_const(int shift);
    logic [63:0] r;
    r = '0;
    if (shift > 0) begin
      r = 64'd1 << (shift - 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_decim_requant_if.sv
// Stream bundle for the decimating requantiser: FIR input, ready/valid output, overrun flag.
// Latency: none (wires only).
// Backpressure: ready_in qualifies the output side; the input side has no stall path.
interface fir_decim_requant_if #(
  parameter int IN_WIDTH  = 36,
  parameter int OUT_WIDTH = 16
);
  logic [IN_WIDTH-1:0]  data_in;
  logic                 valid_in;
  logic [OUT_WIDTH-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 clr_ovr;
  logic                 overrun;

  // Producer / consumer side (drives samples, ready and flag clear).
  modport master (
    output data_in, valid_in, ready_in, clr_ovr,
    input  data_out, valid_out, overrun
  );

  // Requantiser side.
  modport slave (
    input  data_in, valid_in, ready_in, clr_ovr,
    output data_out, valid_out, overrun
  );
endinterface

// File: rtl/fir_fifo2.sv
// 2-entry ready/valid buffer; a push on a full buffer is refused and reported via drop.
// Latency: a push is visible at the head on the following cycle when the buffer was empty.
// Backpressure: never stalls the writer; push+pop on full succeeds, push alone on full drops.
module fir_fifo2
  import fir_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  fill_e        fill_q, fill_d;
  logic [W-1:0] head_q, tail_q;
  logic         pop;
  logic         head_ld, head_from_tail, tail_ld;

  assign empty   = (fill_q == FILL_EMPTY);
  assign full    = (fill_q == FILL_TWO);
  assign out_vld = !empty;
  assign out_dat = head_q;
  assign pop     = out_vld && pop_rdy;
  assign drop    = push && full && !pop;

  // Occupancy register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fill_q <= FILL_EMPTY;
    end else begin
      fill_q <= fill_d;
    end
  end

  // Next occupancy and which storage slots load this cycle.
  always_comb begin
    fill_d         = fill_q;
    head_ld        = 1'b0;
    head_from_tail = 1'b0;
    tail_ld        = 1'b0;
    case (fill_q)
      FILL_EMPTY: begin
        if (push) begin
          head_ld = 1'b1;
          fill_d  = FILL_ONE;
        end
      end
      FILL_ONE: begin
        if (push && pop) begin
          // Head is replaced by the incoming sample; occupancy unchanged.
          head_ld = 1'b1;
        end else if (push) begin
          tail_ld = 1'b1;
          fill_d  = FILL_TWO;
        end else if (pop) begin
          fill_d = FILL_EMPTY;
        end
      end
      FILL_TWO: begin
        if (pop) begin
          head_ld        = 1'b1;
          head_from_tail = 1'b1;
          if (push) begin
            tail_ld = 1'b1;
          end else begin
            fill_d = FILL_ONE;
          end
        end
      end
      default: fill_d = FILL_EMPTY;
    endcase
  end

  // Storage slots; head keeps its last value while the buffer is empty.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (head_ld) begin
        head_q <= head_from_tail ? tail_q : push_dat;
      end
      if (tail_ld) begin
        tail_q <= push_dat;
      end
    end
  end

endmodule

// File: rtl/fir_decim_requant.sv
// Decimate the FIR output stream, round/shift, clip (FIR_DECIM_REQUANT_SAT_EN) or wrap, then buffer.
// Latency: kept sample on cycle T is valid at the output from T+2 if the buffer has room.
// Backpressure: input never stalls; a kept sample arriving at a full, non-popping buffer sets overrun.
module fir_decim_requant
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = out_width(SAMPLE_W, SAMPLE_W, 5),
  parameter int OUT_WIDTH  = SAMPLE_W,
  parameter int FRAC_SHIFT = 15,
  parameter int DECIM      = 4
) (
  input  logic           clk,
  input  logic           arst_n,
  fir_decim_requant_if.slave bus
);

  localparam int              SH_W    = IN_WIDTH + 1 - FRAC_SHIFT;
  localparam int              PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
  localparam logic [63:0]     RND64   = round_const(FRAC_SHIFT);
  localparam logic [IN_WIDTH:0] RND   = RND64[IN_WIDTH:0];

  logic [PH_W-1:0]      phase_q;
  logic                 keep;
  logic [IN_WIDTH:0]    sum;
  logic                 s1_valid;
  logic [SH_W-1:0]      s1_shifted;
  logic [OUT_WIDTH-1:0] req;
  logic                 fifo_vld, fifo_full, fifo_empty, fifo_drop;
  logic [OUT_WIDTH-1:0] fifo_dat;
  logic                 ovr_q;
  logic                 unused_bits;

  assign keep = bus.valid_in && (phase_q == '0);

  // Sign-extend one bit so the rounding add cannot overflow.
  assign sum = {bus.data_in[IN_WIDTH-1], bus.data_in} + RND;

  // Phase counter advances on every input sample and wraps at DECIM-1.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      phase_q <= '0;
    end else if (bus.valid_in) begin
      phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  // Stage 1: register the rounded, arithmetically shifted kept sample.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_valid   <= 1'b0;
      s1_shifted <= '0;
    end else begin
      s1_valid <= keep;
      if (keep) begin
        s1_shifted <= sum[IN_WIDTH:FRAC_SHIFT];
      end
    end
  end

  // Stage 2: reduce the shifted value to the output width.
`ifdef FIR_DECIM_REQUANT_SAT_EN
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  generate
    if (SH_W > OUT_WIDTH) begin : g_clip
      logic [SH_W-OUT_WIDTH:0] top_bits;
      logic                    fits;
      assign top_bits = s1_shifted[SH_W-1:OUT_WIDTH-1];
      // In range when every bit above the output sign bit matches it.
      assign fits     = (&top_bits) || !(|top_bits);
      assign req      = fits ? s1_shifted[OUT_WIDTH-1:0]
                      : (top_bits[SH_W-OUT_WIDTH] ? OUT_MIN : OUT_MAX);
    end else begin : g_noclip
      assign req = s1_shifted[OUT_WIDTH-1:0];
    end
  endgenerate
`else
  assign req = s1_shifted[OUT_WIDTH-1:0];
`endif

  fir_fifo2 #(
    .W (OUT_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .arst_n   (arst_n),
    .push     (s1_valid),
    .push_dat (req),
    .pop_rdy  (bus.ready_in),
    .out_vld  (fifo_vld),
    .out_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ovr_q <= 1'b0;
    end else if (fifo_drop) begin
      ovr_q <= 1'b1;
    end else if (bus.clr_ovr) begin
      ovr_q <= 1'b0;
    end
  end

  assign bus.valid_out = fifo_vld;
  assign bus.data_out  = fifo_dat;
  assign bus.overrun   = ovr_q;

  // Fraction bits below the shift and status outputs not needed here.
  assign unused_bits = ^{sum, s1_shifted, fifo_full, fifo_empty};

endmodule

// File: doc/fir_decim_requant.md
Name: fir_decim_requant

Overview:
- Stage directly downstream of the symmetric even FIR filter.
- Consumes the filter's full-precision output stream (data/valid, no backpressure available upstream).
- Decimates by an integer factor, then rounds, shifts and saturates the result to the system sample width.
- Presents the result on a ready/valid interface through a 2-entry output buffer. Overruns are flagged, never stalled.

Parameters:
- IN_WIDTH, 36, width of the FIR output word (16+16+clog2(5)+1).
- OUT_WIDTH, 16, width of the requantised output sample. Must be <= IN_WIDTH-FRAC_SHIFT+1.
- FRAC_SHIFT, 15, arithmetic right shift applied after rounding. 0 means no shift and no rounding.
- DECIM, 4, decimation factor. DECIM >= 1; 1 means pass every sample.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- data_in  in  IN_WIDTH  signed FIR output sample
- valid_in  in  1  data_in valid this cycle (single-cycle qualifier)
- data_out  out  OUT_WIDTH  signed requantised sample (buffer head)
- valid_out  out  1  data_out holds a valid sample
- ready_in  in  1  downstream accepts data_out this cycle
- clr_ovr  in  1  synchronous clear of the overrun flag
- overrun  out  1  sticky: a kept sample was dropped because the buffer was full

Behaviour:
- Reset (arst_n=0, asynchronous): phase counter=0, stage-1 valid=0, buffer empty.
  - Outputs: valid_out=0, data_out=0, overrun=0.
  - Reset mid-operation discards all in-flight samples immediately.
- Phase counter, range 0..DECIM-1:
  - Increments only on valid_in and wraps DECIM-1 -> 0.
  - A sample is kept when valid_in=1 and phase==0; all others are discarded.
  - Keeps input samples 0, DECIM, 2*DECIM, ... after reset.
- Stage 1 (registered):
  - If FRAC_SHIFT>0: sum = data_in + 2^(FRAC_SHIFT-1) (round half up, toward +inf), computed in IN_WIDTH+1 bits.
  - shifted = sum >>> FRAC_SHIFT (arithmetic).
  - Registered together with s1_valid.
- Stage 2: the saturate/clip result is written into the 2-entry FIFO when s1_valid=1.
- Latency: a kept sample entering on cycle T appears with valid_out=1 from cycle T+2, provided the buffer is not full.
- Stage 1 never stalls. Stage 1 always advances, and a push attempt happens whenever s1_valid=1.
- Buffer rules:
  - Pop when valid_out && ready_in.
  - Push when s1_valid && (not full || pop in the same cycle). Simultaneous push and pop on a full buffer succeeds; occupancy stays 2.
  - Push attempted on full without pop: sample dropped, overrun set to 1 on the next edge.
  - Simultaneous push and pop on a 1-entry buffer: occupancy stays 1, and the head becomes the new sample.
- Output data:
  - data_out is the buffer head while valid_out=1.
  - data_out holds its last value when empty (0 after reset).
  - data_out and valid_out are stable while valid_out && !ready_in.
- overrun:
  - Cleared by clr_ovr=1 at the next edge.
  - If a drop and clr_ovr occur in the same cycle, the set wins.
- ready_in ignored while the buffer is empty. valid_in is not gated by the buffer state.

Optional Feature:
- Macro: FIR_DECIM_REQUANT_SAT_EN.
- Defined: shifted value is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Undefined: low OUT_WIDTH bits are taken (two's-complement wrap). Saves the comparators.
- The overrun behaviour is the same either way.

Decomposition:
- Shared package fir_pkg:
  - Width helper function out_width(in_w, coeff_w, n_coeffs) returning in_w+coeff_w+clog2(n)+1.
  - Default sample width constant (16).
  - Rounding-constant function.
- One sub-module: fir_fifo2, a 2-entry ready/valid buffer with full/empty, push/pop and simultaneous-op handling. It is reused by other stream stages.

Test Plan:
- Rounding, DECIM=1: data_in=3276800 -> 100; 3293184 (100.5*2^15) -> 101; -16384 -> 0; -16385 -> -1. Each has valid_out exactly 2 cycles after valid_in, with ready_in=1.
- Decimation, DECIM=4, ready_in=1: inputs k*32768 for k=0..9 with gaps in valid_in -> outputs 0, 4, 8 only.
- Saturation: data_in=2^34 -> 32767 with SAT_EN, 0 without. data_in=-(2^34) -> -32768 with SAT_EN, 0 without.
- Backpressure/overrun, DECIM=4, ready_in=0: 12 inputs k*32768 -> buffer holds 0, 4; sample 8 dropped; overrun=1. Then ready_in=1 -> 0, 4 delivered in order. clr_ovr pulse -> overrun=0.
- Full push+pop: buffer full, ready_in=1 in the same cycle as a push -> no overrun, and the order is preserved.
- Reset mid-stream: assert arst_n=0 with 2 buffered and 1 in stage 1 -> valid_out=0 and overrun=0 immediately. After release, the first kept sample is the first valid_in.
